// File: rtl/alarm_ctrl.sv
// Alarm-clock keypad/button controller: four-state FSM with registered outputs.
// Optional key-entry timeout is compiled in when KEY_TIMEOUT_EN is defined.
module alarm_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       one_second,
    input  logic       key_valid,
    input  logic [3:0] key,
    input  logic       alarm_btn,
    input  logic       time_btn,
    input  logic       fast_btn,
    output logic [3:0] key_out,
    output logic       shift,
    output logic       load_new_a,
    output logic       load_new_c,
    output logic       reset_count,
    output logic       show_a,
    output logic       show_new_time,
    output logic       fast_watch
);

    typedef enum logic [1:0] {
        SHOW_TIME,
        SHOW_ALARM,
        KEY_ENTRY,
        KEY_WAIT
    } state_t;

    state_t     state_reg, state_next;
    logic [2:0] digit_cnt_reg, digit_cnt_next;
    logic [3:0] key_out_reg, key_out_next;
    logic       shift_reg, shift_next;
    logic       load_a_reg, load_a_next;
    logic       load_c_reg, load_c_next;
    logic       show_a_reg, show_a_next;
    logic       show_new_reg, show_new_next;
    logic       fast_reg, fast_next;
    logic       is_digit;
    logic       timeout_hit;

    assign is_digit = key_valid && (key < 4'd10);

`ifdef KEY_TIMEOUT_EN
    logic [3:0] tmo_reg, tmo_next;

    // Tenth tick: the counter already holds nine ticks and another arrives.
    assign timeout_hit = one_second && (tmo_reg == 4'd9);

    always_comb begin
        tmo_next = tmo_reg;
        if ((state_next != state_reg) || shift_next)
            tmo_next = 4'd0;
        else if (one_second && ((state_reg == KEY_ENTRY) || (state_reg == KEY_WAIT)))
            tmo_next = tmo_reg + 4'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tmo_reg <= 4'd0;
        else
            tmo_reg <= tmo_next;
    end
`else
    logic unused_one_second;
    assign unused_one_second = one_second;
    assign timeout_hit       = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        digit_cnt_next = digit_cnt_reg;
        key_out_next   = key_out_reg;
        shift_next     = 1'b0;
        load_a_next    = 1'b0;
        load_c_next    = 1'b0;
        fast_next      = fast_reg;

        case (state_reg)
            SHOW_TIME: begin
                digit_cnt_next = 3'd0;
                if (fast_btn)
                    fast_next = ~fast_reg;
                if (alarm_btn) begin
                    state_next = SHOW_ALARM;
                end else if (is_digit) begin
                    state_next     = KEY_ENTRY;
                    shift_next     = 1'b1;
                    key_out_next   = key;
                    digit_cnt_next = 3'd1;
                end
            end
            SHOW_ALARM: begin
                if (alarm_btn) begin
                    state_next     = SHOW_TIME;
                    digit_cnt_next = 3'd0;
                end
            end
            KEY_ENTRY: begin
                // A digit beats a coincident timeout tick.
                if (is_digit) begin
                    shift_next     = 1'b1;
                    key_out_next   = key;
                    digit_cnt_next = digit_cnt_reg + 3'd1;
                    if (digit_cnt_reg == 3'd3)
                        state_next = KEY_WAIT;
                end else if (timeout_hit) begin
                    state_next     = SHOW_TIME;
                    digit_cnt_next = 3'd0;
                end
            end
            KEY_WAIT: begin
                if (time_btn) begin
                    load_c_next    = 1'b1;
                    state_next     = SHOW_TIME;
                    digit_cnt_next = 3'd0;
                end else if (alarm_btn) begin
                    load_a_next    = 1'b1;
                    state_next     = SHOW_TIME;
                    digit_cnt_next = 3'd0;
                end else if (timeout_hit) begin
                    state_next     = SHOW_TIME;
                    digit_cnt_next = 3'd0;
                end
            end
            default: begin
                state_next     = SHOW_TIME;
                digit_cnt_next = 3'd0;
            end
        endcase

        // Display levels track the state being entered so they line up with the pulses.
        show_a_next   = (state_next == SHOW_ALARM);
        show_new_next = (state_next == KEY_ENTRY) || (state_next == KEY_WAIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= SHOW_TIME;
            digit_cnt_reg <= 3'd0;
            key_out_reg   <= 4'd0;
            shift_reg     <= 1'b0;
            load_a_reg    <= 1'b0;
            load_c_reg    <= 1'b0;
            show_a_reg    <= 1'b0;
            show_new_reg  <= 1'b0;
            fast_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            digit_cnt_reg <= digit_cnt_next;
            key_out_reg   <= key_out_next;
            shift_reg     <= shift_next;
            load_a_reg    <= load_a_next;
            load_c_reg    <= load_c_next;
            show_a_reg    <= show_a_next;
            show_new_reg  <= show_new_next;
            fast_reg      <= fast_next;
        end
    end

    assign key_out       = key_out_reg;
    assign shift         = shift_reg;
    assign load_new_a    = load_a_reg;
    assign load_new_c    = load_c_reg;
    assign reset_count   = load_c_reg;
    assign show_a        = show_a_reg;
    assign show_new_time = show_new_reg;
    assign fast_watch    = fast_reg;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed-vector bench for alarm_ctrl; timeout scenarios run when KEY_TIMEOUT_EN is defined.
module tb_alarm_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       one_second, key_valid, alarm_btn, time_btn, fast_btn;
    logic [3:0] key;
    logic [3:0] key_out;
    logic       shift, load_new_a, load_new_c, reset_count;
    logic       show_a, show_new_time, fast_watch;

    int vectors     = 0;
    int miscompares = 0;

    alarm_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .one_second   (one_second),
        .key_valid    (key_valid),
        .key          (key),
        .alarm_btn    (alarm_btn),
        .time_btn     (time_btn),
        .fast_btn     (fast_btn),
        .key_out      (key_out),
        .shift        (shift),
        .load_new_a   (load_new_a),
        .load_new_c   (load_new_c),
        .reset_count  (reset_count),
        .show_a       (show_a),
        .show_new_time(show_new_time),
        .fast_watch   (fast_watch)
    );

    always #5 clk = ~clk;

    // Apply one cycle of strobes; outputs are sampled 1 ns after the sampling edge.
    task automatic drive(input logic kv, input logic [3:0] k, input logic ab,
                         input logic tb, input logic fb, input logic os);
        key_valid  = kv;
        key        = k;
        alarm_btn  = ab;
        time_btn   = tb;
        fast_btn   = fb;
        one_second = os;
        @(posedge clk);
        #1;
        key_valid  = 1'b0;
        key        = 4'd0;
        alarm_btn  = 1'b0;
        time_btn   = 1'b0;
        fast_btn   = 1'b0;
        one_second = 1'b0;
        $display("vec t=%0t kv=%b key=%0d ab=%b tb=%b fb=%b os=%b -> key_out=%0d sh=%b la=%b lc=%b rc=%b sa=%b snt=%b fw=%b",
                 $time, kv, k, ab, tb, fb, os, key_out, shift, load_new_a, load_new_c,
                 reset_count, show_a, show_new_time, fast_watch);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({key_out, shift, load_new_a, load_new_c, reset_count, show_a, show_new_time, fast_watch} !== 11'd0) begin
            $display("FAIL reset_outputs: got %b want 0", {key_out, shift, load_new_a, load_new_c,
                     reset_count, show_a, show_new_time, fast_watch});
            miscompares++;
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_time_load;
        logic [3:0] digits [4];
        digits = '{4'd1, 4'd2, 4'd3, 4'd0};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, digits[i], 1'b0, 1'b0, 1'b0, 1'b0);
            vectors++;
            if (shift !== 1'b1 || key_out !== digits[i] || show_new_time !== 1'b1) begin
                $display("FAIL time_load_digit%0d: got sh=%b key_out=%0d snt=%b want sh=1 key_out=%0d snt=1",
                         i, shift, key_out, show_new_time, digits[i]);
                miscompares++;
            end
        end
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (shift !== 1'b0 || key_out !== 4'd0) begin
            $display("FAIL time_load_idle: got sh=%b key_out=%0d want sh=0 key_out=0", shift, key_out);
            miscompares++;
        end
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (load_new_c !== 1'b1 || reset_count !== 1'b1 || load_new_a !== 1'b0 || show_new_time !== 1'b0) begin
            $display("FAIL time_load_pulse: got lc=%b rc=%b la=%b snt=%b want lc=1 rc=1 la=0 snt=0",
                     load_new_c, reset_count, load_new_a, show_new_time);
            miscompares++;
        end
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (load_new_c !== 1'b0 || reset_count !== 1'b0) begin
            $display("FAIL time_load_one_cycle: got lc=%b rc=%b want 0 0", load_new_c, reset_count);
            miscompares++;
        end
    endtask

    task automatic test_priority;
        logic [3:0] digits [4];
        digits = '{4'd0, 4'd7, 4'd0, 4'd0};
        for (int i = 0; i < 4; i++)
            drive(1'b1, digits[i], 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (load_new_c !== 1'b1 || reset_count !== 1'b1 || load_new_a !== 1'b0) begin
            $display("FAIL priority_time_over_alarm: got lc=%b rc=%b la=%b want lc=1 rc=1 la=0",
                     load_new_c, reset_count, load_new_a);
            miscompares++;
        end
        vectors++;
        if (show_a !== 1'b0 || show_new_time !== 1'b0) begin
            $display("FAIL priority_back_home: got sa=%b snt=%b want 0 0", show_a, show_new_time);
            miscompares++;
        end
    endtask

    task automatic test_alarm_view;
        // key_out holds 0 from the previous entry.
        drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (show_a !== 1'b1 || show_new_time !== 1'b0) begin
            $display("FAIL alarm_view_on: got sa=%b snt=%b want sa=1 snt=0", show_a, show_new_time);
            miscompares++;
        end
        drive(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (shift !== 1'b0 || key_out !== 4'd0 || show_a !== 1'b1) begin
            $display("FAIL alarm_view_key_ignored: got sh=%b key_out=%0d sa=%b want sh=0 key_out=0 sa=1",
                     shift, key_out, show_a);
            miscompares++;
        end
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        vectors++;
        if (load_new_c !== 1'b0 || show_a !== 1'b1 || fast_watch !== 1'b0) begin
            $display("FAIL alarm_view_btn_ignored: got lc=%b sa=%b fw=%b want lc=0 sa=1 fw=0",
                     load_new_c, show_a, fast_watch);
            miscompares++;
        end
        drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (show_a !== 1'b0) begin
            $display("FAIL alarm_view_off: got sa=%b want 0", show_a);
            miscompares++;
        end
        drive(1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (shift !== 1'b0 || show_new_time !== 1'b0 || key_out !== 4'd0) begin
            $display("FAIL nondigit_ignored: got sh=%b snt=%b key_out=%0d want 0 0 0",
                     shift, show_new_time, key_out);
            miscompares++;
        end
    endtask

    task automatic test_alarm_load;
        drive(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (load_new_a !== 1'b0 || load_new_c !== 1'b0 || show_new_time !== 1'b1 || key_out !== 4'd6) begin
            $display("FAIL entry_btn_ignored: got la=%b lc=%b snt=%b key_out=%0d want 0 0 1 6",
                     load_new_a, load_new_c, show_new_time, key_out);
            miscompares++;
        end
        drive(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (shift !== 1'b0 || key_out !== 4'd0 || show_new_time !== 1'b1) begin
            $display("FAIL wait_key_ignored: got sh=%b key_out=%0d snt=%b want 0 0 1",
                     shift, key_out, show_new_time);
            miscompares++;
        end
        drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (load_new_a !== 1'b1 || load_new_c !== 1'b0 || reset_count !== 1'b0 || show_new_time !== 1'b0) begin
            $display("FAIL alarm_load: got la=%b lc=%b rc=%b snt=%b want 1 0 0 0",
                     load_new_a, load_new_c, reset_count, show_new_time);
            miscompares++;
        end
    endtask

    task automatic test_fast_and_reset_mid;
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        vectors++;
        if (fast_watch !== 1'b1) begin
            $display("FAIL fast_toggle_on: got fw=%b want 1", fast_watch);
            miscompares++;
        end
        drive(1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        vectors++;
        if (fast_watch !== 1'b1) begin
            $display("FAIL fast_ignored_in_entry: got fw=%b want 1", fast_watch);
            miscompares++;
        end
        drive(1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if ({key_out, shift, load_new_a, load_new_c, reset_count, show_a, show_new_time, fast_watch} !== 11'd0) begin
            $display("FAIL reset_mid_entry: got %b want 0", {key_out, shift, load_new_a, load_new_c,
                     reset_count, show_a, show_new_time, fast_watch});
            miscompares++;
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (shift !== 1'b1 || key_out !== 4'd6) begin
            $display("FAIL post_reset_first_digit: got sh=%b key_out=%0d want 1 6", shift, key_out);
            miscompares++;
        end
        drive(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (load_new_c !== 1'b0 || show_new_time !== 1'b1) begin
            $display("FAIL post_reset_count_3: got lc=%b snt=%b want 0 1", load_new_c, show_new_time);
            miscompares++;
        end
        drive(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (load_new_c !== 1'b1 || reset_count !== 1'b1) begin
            $display("FAIL post_reset_count_4: got lc=%b rc=%b want 1 1", load_new_c, reset_count);
            miscompares++;
        end
    endtask

    task automatic test_timeout;
        drive(1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef KEY_TIMEOUT_EN
        repeat (9) drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (show_new_time !== 1'b1) begin
            $display("FAIL timeout_9_ticks: got snt=%b want 1", show_new_time);
            miscompares++;
        end
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (show_new_time !== 1'b0 || load_new_a !== 1'b0 || load_new_c !== 1'b0) begin
            $display("FAIL timeout_10th_tick: got snt=%b la=%b lc=%b want 0 0 0",
                     show_new_time, load_new_a, load_new_c);
            miscompares++;
        end
        drive(1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (9) drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        // Digit coincident with a tick: digit accepted, counter restarts.
        drive(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (shift !== 1'b1 || key_out !== 4'd2 || show_new_time !== 1'b1) begin
            $display("FAIL timeout_key_wins: got sh=%b key_out=%0d snt=%b want 1 2 1",
                     shift, key_out, show_new_time);
            miscompares++;
        end
        repeat (9) drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (show_new_time !== 1'b1) begin
            $display("FAIL timeout_restart: got snt=%b want 1", show_new_time);
            miscompares++;
        end
        drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (show_new_time !== 1'b0) begin
            $display("FAIL timeout_restart_expire: got snt=%b want 0", show_new_time);
            miscompares++;
        end
`else
        repeat (12) drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (show_new_time !== 1'b1) begin
            $display("FAIL no_timeout_wait: got snt=%b want 1", show_new_time);
            miscompares++;
        end
        drive(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (shift !== 1'b1 || key_out !== 4'd2) begin
            $display("FAIL tick_key_same_cycle: got sh=%b key_out=%0d want 1 2", shift, key_out);
            miscompares++;
        end
        drive(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (load_new_a !== 1'b1 || show_new_time !== 1'b0) begin
            $display("FAIL no_timeout_exit: got la=%b snt=%b want 1 0", load_new_a, show_new_time);
            miscompares++;
        end
`endif
    endtask

    initial begin
        reset      = 1'b1;
        one_second = 1'b0;
        key_valid  = 1'b0;
        key        = 4'd0;
        alarm_btn  = 1'b0;
        time_btn   = 1'b0;
        fast_btn   = 1'b0;
        test_reset();
        test_time_load();
        test_priority();
        test_alarm_view();
        test_alarm_load();
        test_fast_and_reset_mid();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
